// File: rtl/liteic_pkg.sv
// ---------------------------------------------------------------------------
// liteic_pkg
// Shared constants and types for the lite interconnect slave-side read node.
//   IC_NUM_MASTER_SLOTS : number of crossbar master slots
//   IC_ARADDR_WIDTH     : full read address width (node uses the low 12 bits
//                         less, i.e. the in-region part)
//   IC_RDATA_WIDTH      : packed {r_data, r_resp} width
//   node_state_e        : read node FSM state encoding
// ---------------------------------------------------------------------------
package liteic_pkg;

    localparam int IC_NUM_MASTER_SLOTS = 4;
    localparam int IC_ARADDR_WIDTH     = 20;
    localparam int IC_RDATA_W          = 32;
    localparam int IC_RRESP_W          = 2;
    localparam int IC_RDATA_WIDTH      = IC_RDATA_W + IC_RRESP_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } node_state_e;

endpackage

// File: rtl/liteic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// liteic_rr_arbiter
// Round-robin arbiter. The search starts at the index after the last
// completed grant and wraps N-1 -> 0; out of reset master 0 has priority.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   req_i         : request vector
//   upd_i         : update enable, moves the pointer to upd_gnt_i
//   upd_gnt_i     : one-hot grant whose index becomes the new "last" index
//   gnt_o         : combinational one-hot grant (all-zero when no request)
// ---------------------------------------------------------------------------
module liteic_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    input  logic [N-1:0] upd_gnt_i,
    output logic [N-1:0] gnt_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;

    // Walk the requests starting one past the last winner; first hit wins.
    always_comb begin
        automatic logic found = 1'b0;
        automatic int   idx   = 0;
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(last_q) + 1 + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            for (int i = 0; i < N; i++) begin
                if (upd_gnt_i[i]) begin
                    last_d = IW'(i);
                end
            end
        end
    end

    // "Last" = N-1 so that the first search starts at master 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/liteic_slave_node_read.sv
// ---------------------------------------------------------------------------
// liteic_slave_node_read
// Slave-side read node of the lite interconnect. Arbitrates read requests
// from NUM_MST crossbar masters, issues one AR at a time to the slave and
// routes the single R beat back to the granted master.
//
// Handshake rule for every channel: a transfer happens in a cycle where both
// valid and ready are high; a valid source holds its payload stable until
// that cycle.
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   cbar_reqst_val_i    : per-master read request valid
//   cbar_reqst_rdy_o    : per-master request accept (only in IDLE, one-hot)
//   cbar_reqst_data_i   : per-master in-region address
//   cbar_resp_val_o     : per-master response valid (granted bit only)
//   cbar_resp_rdy_i     : per-master response ready
//   cbar_resp_data_o    : response {r_data, r_resp}, shared by all masters
//   slv_ar_*            : slave AR channel
//   slv_r_*             : slave R channel
//   dbg_state_o         : current FSM state, for observation
// ---------------------------------------------------------------------------
module liteic_slave_node_read
    import liteic_pkg::*;
#(
    parameter int NUM_MST = liteic_pkg::IC_NUM_MASTER_SLOTS,
    parameter int ADDR_W  = liteic_pkg::IC_ARADDR_WIDTH - 12,
    parameter int DATA_W  = liteic_pkg::IC_RDATA_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_MST-1:0] cbar_reqst_val_i,
    output logic [NUM_MST-1:0] cbar_reqst_rdy_o,
    input  logic [ADDR_W-1:0]  cbar_reqst_data_i [NUM_MST],
    output logic [NUM_MST-1:0] cbar_resp_val_o,
    input  logic [NUM_MST-1:0] cbar_resp_rdy_i,
    output logic [DATA_W-1:0]  cbar_resp_data_o,
    output logic               slv_ar_valid_o,
    input  logic               slv_ar_ready_i,
    output logic [ADDR_W-1:0]  slv_ar_addr_o,
    input  logic               slv_r_valid_i,
    output logic               slv_r_ready_o,
    input  logic [DATA_W-1:0]  slv_r_data_i,
    output node_state_e        dbg_state_o
);

    node_state_e        state_q, state_d;
    logic [NUM_MST-1:0] gnt_q,   gnt_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;

    logic [NUM_MST-1:0] arb_gnt;
    logic               arb_upd;

    liteic_rr_arbiter #(
        .N (NUM_MST)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (cbar_reqst_val_i),
        .upd_i     (arb_upd),
        .upd_gnt_i (gnt_q),
        .gnt_o     (arb_gnt)
    );

    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        addr_d           = addr_q;
        arb_upd          = 1'b0;
        cbar_reqst_rdy_o = '0;
        cbar_resp_val_o  = '0;
        cbar_resp_data_o = '0;
        slv_ar_valid_o   = 1'b0;
        slv_ar_addr_o    = '0;
        slv_r_ready_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|cbar_reqst_val_i) begin
                    cbar_reqst_rdy_o = arb_gnt;
                    gnt_d            = arb_gnt;
                    for (int i = 0; i < NUM_MST; i++) begin
                        if (arb_gnt[i]) begin
                            addr_d = cbar_reqst_data_i[i];
                        end
                    end
                    state_d = ST_AR;
                end
            end

            ST_AR: begin
                slv_ar_valid_o = 1'b1;
                slv_ar_addr_o  = addr_q;
                if (slv_ar_ready_i) begin
                    state_d = ST_R;
                end
            end

            ST_R: begin
                // Pure pass-through between the slave and the granted master.
                cbar_resp_val_o  = gnt_q & {NUM_MST{slv_r_valid_i}};
                cbar_resp_data_o = slv_r_data_i;
                slv_r_ready_o    = |(gnt_q & cbar_resp_rdy_i);
                if (slv_r_valid_i && slv_r_ready_o) begin
                    arb_upd = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: doc/liteic_slave_node_read.md
LITEIC_SLAVE_NODE_READ -- requirements
Module: liteic_slave_node_read

Interface
REQ-001 SHALL have parameter NUM_MST, default liteic_pkg::IC_NUM_MASTER_SLOTS (4): number of crossbar master slots.
REQ-002 SHALL have parameter ADDR_W, default liteic_pkg::IC_ARADDR_WIDTH-12 (8): in-region read address width.
REQ-003 SHALL have parameter DATA_W, default liteic_pkg::IC_RDATA_WIDTH: packed {r_data, r_resp} width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 cbar_reqst_val_i  in  NUM_MST  per-master read request valid.
REQ-008 cbar_reqst_rdy_o  out  NUM_MST  per-master request accept.
REQ-009 cbar_reqst_data_i  in  NUM_MST x ADDR_W (unpacked array)  per-master address.
REQ-010 cbar_resp_val_o  out  NUM_MST  per-master response valid.
REQ-011 cbar_resp_rdy_i  in  NUM_MST  per-master response ready.
REQ-012 cbar_resp_data_o  out  DATA_W  response data, shared by all masters.
REQ-013 slv_ar_valid_o / slv_ar_ready_i / slv_ar_addr_o  out/in/out  1/1/ADDR_W  slave AR channel.
REQ-014 slv_r_valid_i / slv_r_ready_o / slv_r_data_i  in/out/in  1/1/DATA_W  slave R channel.

Function
REQ-015 SHALL implement FSM IDLE -> AR -> R -> IDLE, one outstanding read at a time.
REQ-016 IDLE: if any cbar_reqst_val_i bit set, SHALL pick one master round-robin, assert only its cbar_reqst_rdy_o bit in that cycle, register the one-hot grant and its address, go to AR.
REQ-017 Round-robin search SHALL start at the master index after the last completed grant, wrapping NUM_MST-1 -> 0; after reset, search starts at master 0.
REQ-018 cbar_reqst_rdy_o SHALL be all-zero in AR and R, and in IDLE when no request is valid.
REQ-019 AR: slv_ar_valid_o=1, slv_ar_addr_o=registered address held stable; on slv_ar_ready_i=1 go to R; wait indefinitely otherwise.
REQ-020 Latency: request accepted in cycle N gives slv_ar_valid_o=1 in cycle N+1 at the earliest.
REQ-021 R: cbar_resp_val_o = slv_r_valid_i on the granted bit only, slv_r_ready_o = cbar_resp_rdy_i[granted], cbar_resp_data_o = slv_r_data_i, all combinational pass-through.
REQ-022 On slv_r_valid_i & slv_r_ready_o in R: go to IDLE and update the round-robin pointer to the granted index.
REQ-023 Outside R: cbar_resp_val_o='0, slv_r_ready_o=0, cbar_resp_data_o='0.
REQ-024 slv_r_valid_i in IDLE or AR SHALL be ignored (no ready, no forwarding).
REQ-025 A single persistent requester SHALL be re-granted each transaction, with exactly one IDLE cycle between completion and next acceptance.
REQ-026 Requests from non-granted masters SHALL stay pending (not accepted) until their round-robin turn.

Reset
REQ-027 On rst_i: state=IDLE, grant='0, address='0, pointer so that master 0 has priority; all outputs 0.
REQ-028 Reset mid-transaction SHALL abandon it immediately with no further slave or master handshake.

Structure
REQ-029 IC_NUM_MASTER_SLOTS, IC_ARADDR_WIDTH, IC_RDATA_WIDTH and the FSM state enum SHALL live in liteic_pkg.
REQ-030 Arbitration SHALL be one sub-module liteic_rr_arbiter (request vector, update enable, one-hot grant out).
REQ-031 Implementation target: 120-400 lines of RTL including the arbiter.

Verification
REQ-032 Single read: master 2 requests addr 0x3C; slave ar_ready after 2 cycles; r_data 0xDEADBEEF,resp OKAY -> rdy_o[2] cycle 0, ar_valid cycles 1-3 addr 0x3C, resp_val_o=4'b0100 with the data.
REQ-033 Contention: masters 0,1,3 request simultaneously from reset -> grant order 0,1,3; master 0 re-requesting after first completion is served after 3.
REQ-034 Backpressure: master holds cbar_resp_rdy_i=0 for 5 cycles with slv_r_valid_i=1 -> slv_r_ready_o=0 throughout, FSM stays in R, completes in cycle 6.
REQ-035 Spurious response: slv_r_valid_i=1 while in IDLE/AR -> slv_r_ready_o=0, cbar_resp_val_o='0.
REQ-036 Reset in R: assert rst_i while in R with pending slave data -> all outputs 0 asynchronously; next request from master 3 and master 0 together grants master 0.
